// File: rtl/psram_arbiter_pkg.sv
// Shared types, widths and the round-robin selection helper for the PSRAM arbiter.
package psram_arbiter_pkg;

    localparam int unsigned PSRAM_ADDR_W = 22;
    localparam int unsigned PSRAM_DATA_W = 16;
    localparam int unsigned MAX_PORTS    = 4;
    localparam int unsigned PORT_IDX_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    // One-hot pick of the first set req bit at or after last+1, wrapping modulo n.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0]  req,
        input logic [PORT_IDX_W-1:0] last,
        input int unsigned           n
    );
        logic [MAX_PORTS-1:0]  pick;
        logic [PORT_IDX_W-1:0] idx;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            idx = PORT_IDX_W'((32'(last) + k) % n);
            if (k <= n && pick == '0 && req[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/psram_arbiter_picker.sv
// Combinational requester selector: fixed priority (port 0 first) or round-robin after i_last.
module arb_picker
    import psram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 3,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic [NUM_PORTS-1:0]  i_req,
    input  logic [PORT_IDX_W-1:0] i_last,
    output logic [NUM_PORTS-1:0]  o_onehot_c,
    output logic [PORT_IDX_W-1:0] o_index_c,
    output logic                  o_valid_c
);

    logic [MAX_PORTS-1:0]  w_pick;
    logic [PORT_IDX_W-1:0] w_start;

    // Fixed priority is round-robin that always restarts after the highest port.
    assign w_start    = (ROUND_ROBIN != 0) ? i_last : PORT_IDX_W'(NUM_PORTS - 1);
    assign w_pick     = rr_pick(MAX_PORTS'(i_req), w_start, NUM_PORTS);
    assign o_onehot_c = w_pick[NUM_PORTS-1:0];
    assign o_valid_c  = |w_pick;

    always_comb begin
        o_index_c = '0;
        for (int i = 0; i < int'(MAX_PORTS); i++) begin
            if (w_pick[i]) begin
                o_index_c = PORT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Single-outstanding PSRAM transaction sequencer shared by NUM_PORTS requesters,
// with edge-qualified handshakes and a per-transaction timeout.
module psram_arbiter
    import psram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 3,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              we,
    input  logic [NUM_PORTS*PSRAM_ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*PSRAM_DATA_W-1:0] wdata,
    input  logic [NUM_PORTS*2-1:0]            be,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [NUM_PORTS-1:0]              done,
    output logic                              err,
    output logic [PSRAM_DATA_W-1:0]           rdata,
    output logic [PSRAM_ADDR_W-1:0]           mem_addr,
    output logic                              mem_write_en,
    output logic                              mem_read_en,
    output logic [PSRAM_DATA_W-1:0]           mem_data_in,
    output logic                              mem_write_high_byte,
    output logic                              mem_write_low_byte,
    input  logic                              mem_write_ack,
    input  logic                              mem_read_ack,
    input  logic                              mem_read_avail,
    input  logic [PSRAM_DATA_W-1:0]           mem_data_out,
    input  logic                              mem_busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  r_state, w_state_nxt;
    logic [PORT_IDX_W-1:0]   r_last, w_last_nxt;
    logic [NUM_PORTS-1:0]    r_grant, w_grant_nxt, r_done, w_done_nxt;
    logic                    r_err, w_err_nxt;
    logic [PSRAM_DATA_W-1:0] r_rdata, w_rdata_nxt, r_wdata, w_wdata_nxt;
    logic                    r_we, w_we_nxt, r_wen, w_wen_nxt, r_ren, w_ren_nxt;
    logic [PSRAM_ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [1:0]              r_be, w_be_nxt;
    logic [TMO_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_prev_wack, r_prev_rack, r_prev_avail, r_prev_busy;

    logic [NUM_PORTS-1:0]    w_pick_onehot;
    logic [PORT_IDX_W-1:0]   w_pick_index;
    logic                    w_pick_valid;
    logic                    w_ack_ev, w_fin_ev, w_tmo;

    logic [MAX_PORTS-1:0]    w_port_we;
    logic [PSRAM_ADDR_W-1:0] w_port_addr  [MAX_PORTS];
    logic [PSRAM_DATA_W-1:0] w_port_wdata [MAX_PORTS];
    logic [1:0]              w_port_be    [MAX_PORTS];

    // Unpack per-port request fields; unused slots read as zero.
    for (genvar g = 0; g < int'(MAX_PORTS); g++) begin : g_port
        if (g < int'(NUM_PORTS)) begin : g_used
            assign w_port_we[g]    = we[g];
            assign w_port_addr[g]  = addr[g*PSRAM_ADDR_W +: PSRAM_ADDR_W];
            assign w_port_wdata[g] = wdata[g*PSRAM_DATA_W +: PSRAM_DATA_W];
            assign w_port_be[g]    = be[g*2 +: 2];
        end else begin : g_unused
            assign w_port_we[g]    = 1'b0;
            assign w_port_addr[g]  = '0;
            assign w_port_wdata[g] = '0;
            assign w_port_be[g]    = '0;
        end
    end

    arb_picker #(
        .NUM_PORTS  (NUM_PORTS),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_picker (
        .i_req     (req),
        .i_last    (r_last),
        .o_onehot_c(w_pick_onehot),
        .o_index_c (w_pick_index),
        .o_valid_c (w_pick_valid)
    );

    // Only rising acks/avail and the falling edge of busy advance the sequence.
    assign w_ack_ev = r_we ? (mem_write_ack & ~r_prev_wack) : (mem_read_ack & ~r_prev_rack);
    assign w_fin_ev = r_we ? (~mem_busy & r_prev_busy) : (mem_read_avail & ~r_prev_avail);
    assign w_tmo    = (r_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_pick_valid) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = WAIT_ACK;
            WAIT_ACK:  if (w_ack_ev) w_state_nxt = WAIT_DONE;
                       else if (w_tmo) w_state_nxt = DONE;
            WAIT_DONE: if (w_fin_ev || w_tmo) w_state_nxt = DONE;
            DONE:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        w_wen_nxt   = 1'b0;
        w_ren_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_onehot;
                    w_last_nxt  = w_pick_index;
                    w_we_nxt    = w_port_we[w_pick_index];
                    w_addr_nxt  = w_port_addr[w_pick_index];
                    w_wdata_nxt = w_port_wdata[w_pick_index];
                    w_be_nxt    = w_port_be[w_pick_index];
                    w_wen_nxt   = w_port_we[w_pick_index];
                    w_ren_nxt   = ~w_port_we[w_pick_index];
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_ACK: begin
                w_cnt_nxt = r_cnt + TMO_W'(1);
                if (!w_ack_ev && w_tmo) begin
                    w_done_nxt  = r_grant;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end
            end
            WAIT_DONE: begin
                w_cnt_nxt = r_cnt + TMO_W'(1);
                if (w_fin_ev) begin
                    w_done_nxt = r_grant;
                    if (!r_we) w_rdata_nxt = mem_data_out;
                end else if (w_tmo) begin
                    w_done_nxt  = r_grant;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end
            end
            DONE:    w_grant_nxt = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last       <= PORT_IDX_W'(NUM_PORTS - 1);
            r_grant      <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_wen        <= 1'b0;
            r_ren        <= 1'b0;
            r_cnt        <= '0;
            r_prev_wack  <= 1'b0;
            r_prev_rack  <= 1'b0;
            r_prev_avail <= 1'b0;
            r_prev_busy  <= 1'b0;
        end else begin
            r_last       <= w_last_nxt;
            r_grant      <= w_grant_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_rdata      <= w_rdata_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_be         <= w_be_nxt;
            r_wen        <= w_wen_nxt;
            r_ren        <= w_ren_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_wack  <= mem_write_ack;
            r_prev_rack  <= mem_read_ack;
            r_prev_avail <= mem_read_avail;
            r_prev_busy  <= mem_busy;
        end
    end

    assign grant               = r_grant;
    assign done                = r_done;
    assign err                 = r_err;
    assign rdata               = r_rdata;
    assign mem_addr            = r_addr;
    assign mem_write_en        = r_wen;
    assign mem_read_en         = r_ren;
    assign mem_data_in         = r_wdata;
    assign mem_write_high_byte = r_be[1];
    assign mem_write_low_byte  = r_be[0];

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one PSRAM handshake model.
module tb_psram_arbiter;

    typedef struct {
        int          port;
        bit          err;
        bit          rd;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req, we;
    logic [65:0] addr;
    logic [47:0] wdata;
    logic [5:0]  be;

    logic [2:0]  grant_m, done_m, grant_f, done_f;
    logic        err_m, err_f;
    logic [15:0] rdata_m, rdata_f, din_m, din_f;
    logic [21:0] maddr_m, maddr_f;
    logic        wen_m, ren_m, hb_m, lb_m, wen_f, ren_f, hb_f, lb_f;

    logic        wack, rack, avail, busy;
    logic [15:0] dout;
    bit          m_active, m_is_wr, no_rack;
    int          m_cnt;
    logic [15:0] model_rdata;

    int          cyc = 0;
    int          n_tests = 0, n_fail = 0;
    int          n_wen, n_ren, wen_cyc, ren_cyc;
    logic [21:0] wen_addr, ren_addr;
    logic [15:0] wen_data;
    logic [1:0]  wen_be;
    exp_t        q_m[$], q_f[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psram_arbiter #(.NUM_PORTS(3), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .grant(grant_m), .done(done_m), .err(err_m), .rdata(rdata_m),
        .mem_addr(maddr_m), .mem_write_en(wen_m), .mem_read_en(ren_m), .mem_data_in(din_m),
        .mem_write_high_byte(hb_m), .mem_write_low_byte(lb_m),
        .mem_write_ack(wack), .mem_read_ack(rack), .mem_read_avail(avail),
        .mem_data_out(dout), .mem_busy(busy));

    psram_arbiter #(.NUM_PORTS(3), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(15)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .grant(grant_f), .done(done_f), .err(err_f), .rdata(rdata_f),
        .mem_addr(maddr_f), .mem_write_en(wen_f), .mem_read_en(ren_f), .mem_data_in(din_f),
        .mem_write_high_byte(hb_f), .mem_write_low_byte(lb_f),
        .mem_write_ack(wack), .mem_read_ack(rack), .mem_read_avail(avail),
        .mem_data_out(dout), .mem_busy(busy));

    // PSRAM model: write ack 3 cycles after write_en, busy falls 5 later; read ack at 3, avail at 5.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_active <= 1'b0; m_cnt <= 0;
            wack <= 1'b0; rack <= 1'b0; avail <= 1'b0; busy <= 1'b0; dout <= '0;
        end else begin
            wack <= 1'b0; rack <= 1'b0; avail <= 1'b0;
            if (!m_active && (wen_m || ren_m)) begin
                m_active <= 1'b1; m_is_wr <= wen_m; m_cnt <= 1; busy <= 1'b1;
            end else if (m_active) begin
                m_cnt <= m_cnt + 1;
                if (m_is_wr) begin
                    if (m_cnt == 3) wack <= 1'b1;
                    if (m_cnt == 8) begin busy <= 1'b0; m_active <= 1'b0; end
                end else begin
                    if (m_cnt == 3 && !no_rack) rack <= 1'b1;
                    if (m_cnt == 5) begin
                        avail <= 1'b1; dout <= model_rdata; busy <= 1'b0; m_active <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int pm, input int pf, input bit er, input bit rd, input logic [15:0] rv);
        q_m.push_back('{port: pm, err: er, rd: rd, rdata: rv});
        q_f.push_back('{port: pf, err: er, rd: rd, rdata: rv});
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [2:0] d, input logic [2:0] g,
                       input logic ev, input logic [15:0] rv);
        check({tag, "_done_port"}, 64'(d), 64'(3'b001 << e.port));
        check({tag, "_grant"}, 64'(g), 64'(3'b001 << e.port));
        check({tag, "_err"}, 64'(ev), 64'(e.err));
        if (e.rd) check({tag, "_rdata"}, 64'(rv), 64'(e.rdata));
    endtask

    task automatic mon_step();
        exp_t e;
        if (reset_n) begin
            if (wen_m) begin
                n_wen++; wen_cyc = cyc; wen_addr = maddr_m; wen_data = din_m; wen_be = {hb_m, lb_m};
            end
            if (ren_m) begin
                n_ren++; ren_cyc = cyc; ren_addr = maddr_m;
            end
            if (|done_m) begin
                if (q_m.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL main_unexpected_done: got done=%b, expected none", done_m);
                end else begin
                    e = q_m.pop_front();
                    cmp("main", e, done_m, grant_m, err_m, rdata_m);
                end
            end
            if (|done_f) begin
                if (q_f.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL fp_unexpected_done: got done=%b, expected none", done_f);
                end else begin
                    e = q_f.pop_front();
                    cmp("fp", e, done_f, grant_f, err_f, rdata_f);
                end
            end
        end
    endtask

    task automatic wait_done(input int port, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_m[port]) begin
                dcyc = cyc;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL wait_done_port%0d: got no done within 400 cycles, expected a done pulse", port);
    endtask

    function automatic logic outputs_any(input bit fp);
        if (fp) return |{grant_f, done_f, err_f, rdata_f, maddr_f, wen_f, ren_f, din_f, hb_f, lb_f};
        return |{grant_m, done_m, err_m, rdata_m, maddr_m, wen_m, ren_m, din_m, hb_m, lb_m};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, d2, ndone;
        bit seen;
        reset_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        no_rack = 1'b0; model_rdata = '0;
        n_wen = 0; n_ren = 0; wen_cyc = 0; ren_cyc = 0;
        fork
            forever begin @(negedge clk); mon_step(); end
        join_none

        repeat (3) tick();
        check("reset_outputs_main", 64'(outputs_any(0)), 64'(0));
        check("reset_outputs_fp", 64'(outputs_any(1)), 64'(0));
        reset_n = 1'b1;
        tick();

        // All ports request continuously: RR rotates 0,1,2; fixed priority keeps port 0.
        we = 3'b111; be = 6'b111111;
        addr = {22'h000300, 22'h000200, 22'h000100};
        wdata = {16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 6; k++) push_exp(k % 3, 0, 1'b0, 1'b0, 16'h0);
        req = 3'b111;
        ndone = 0;
        for (int i = 0; i < 600 && ndone < 6; i++) begin
            tick();
            if (|done_m) begin
                ndone++;
                if (ndone == 6) req = '0;
            end
        end
        check("rr_done_count", 64'(ndone), 64'(6));
        repeat (2) tick();

        // Single write on port 2.
        n_wen = 0;
        we = 3'b100; addr[44 +: 22] = 22'h000123; wdata[32 +: 16] = 16'hBEEF; be[4 +: 2] = 2'b11;
        push_exp(2, 2, 1'b0, 1'b0, 16'h0);
        req = 3'b100;
        wait_done(2, d);
        req = '0;
        check("wr_en_pulses", 64'(n_wen), 64'(1));
        check("wr_addr", 64'(wen_addr), 64'(22'h000123));
        check("wr_data", 64'(wen_data), 64'(16'hBEEF));
        check("wr_be", 64'(wen_be), 64'(2'b11));
        repeat (2) tick();

        // Single read on port 1 at the top of the address space.
        n_ren = 0; model_rdata = 16'h1234;
        we = 3'b000; addr[22 +: 22] = 22'h3FFFFF;
        push_exp(1, 1, 1'b0, 1'b1, 16'h1234);
        req = 3'b010;
        wait_done(1, d);
        req = '0;
        check("rd_en_pulses", 64'(n_ren), 64'(1));
        check("rd_addr", 64'(ren_addr), 64'(22'h3FFFFF));
        repeat (2) tick();

        // Read ack never arrives: abort with err after 15 wait cycles.
        no_rack = 1'b1;
        addr[22 +: 22] = 22'h000055;
        push_exp(1, 1, 1'b1, 1'b1, 16'h0000);
        req = 3'b010;
        wait_done(1, d);
        req = '0;
        check("timeout_latency", 64'(d - ren_cyc), 64'(17));
        no_rack = 1'b0;
        repeat (2) tick();

        model_rdata = 16'h5A5A; addr[0 +: 22] = 22'h000777;
        push_exp(0, 0, 1'b0, 1'b1, 16'h5A5A);
        req = 3'b001;
        wait_done(0, d);
        req = '0;
        repeat (2) tick();

        // Back-to-back writes on port 0 with req held through done.
        we = 3'b001; addr[0 +: 22] = 22'h000AAA; wdata[0 +: 16] = 16'h1111; be[0 +: 2] = 2'b01;
        push_exp(0, 0, 1'b0, 1'b0, 16'h0);
        push_exp(0, 0, 1'b0, 1'b0, 16'h0);
        req = 3'b001;
        wait_done(0, d);
        addr[0 +: 22] = 22'h02BBBB; wdata[0 +: 16] = 16'h2222;
        n_wen = 0;
        for (int i = 0; i < 50 && n_wen == 0; i++) tick();
        check("b2b_issue_gap", 64'(wen_cyc - d), 64'(2));
        check("b2b_new_addr", 64'(wen_addr), 64'(22'h02BBBB));
        check("b2b_new_data", 64'(wen_data), 64'(16'h2222));
        wait_done(0, d2);
        req = '0;
        repeat (2) tick();

        // Reset during WAIT_DONE: abandoned without done, then re-granted.
        we = 3'b100; addr[44 +: 22] = 22'h00ABCD; wdata[32 +: 16] = 16'hCAFE; be[4 +: 2] = 2'b10;
        push_exp(2, 2, 1'b0, 1'b0, 16'h0);
        req = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (wack) seen = 1'b1;
        end
        check("rst_mid_ack_seen", 64'(seen), 64'(1));
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs_main", 64'(outputs_any(0)), 64'(0));
        check("rst_mid_outputs_fp", 64'(outputs_any(1)), 64'(0));
        repeat (3) tick();
        reset_n = 1'b1;
        wait_done(2, d);
        req = '0;

        repeat (10) tick();
        check("sb_drain_main", 64'(q_m.size()), 64'(0));
        check("sb_drain_fp", 64'(q_f.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares one PSRAM controller (psram, CLOCK_SPEED 85.9) between NUM_PORTS requesters, e.g. APF bridge loader (writes), bridge unloader (reads) and the save-state engine (read/write).
- Replaces ad-hoc combinational address/enable muxing with a single-outstanding, edge-qualified transaction sequencer.
- Adds fixed-priority or round-robin arbitration and a per-transaction timeout.
- Sits in the clk_mem_85_9 domain between requester logic and the psram instance.

Parameters:
- NUM_PORTS, 3, number of requesters (2..4)
- ROUND_ROBIN, 1, 0 = fixed priority (port 0 highest), 1 = rotate starting after the last granted port
- TIMEOUT_CYCLES, 1023, cycles allowed in any wait state before abort

Ports:
- clk  in  1  memory clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_PORTS  level request per port; held until done
- we  in  NUM_PORTS  1 = write, 0 = read
- addr  in  NUM_PORTS*22  16-bit word address per port, port i at [22i+21:22i]
- wdata  in  NUM_PORTS*16  write data per port
- be  in  NUM_PORTS*2  byte enables per port, {hi, lo}
- grant  out  NUM_PORTS  one-hot, high from ISSUE through DONE
- done  out  NUM_PORTS  one-cycle completion pulse for the granted port
- err  out  1  valid with done; 1 = timeout
- rdata  out  16  read data, valid with done on reads
- mem_addr  out  22  to psram addr
- mem_write_en  out  1  to psram
- mem_read_en  out  1  to psram
- mem_data_in  out  16  to psram
- mem_write_high_byte  out  1  to psram
- mem_write_low_byte  out  1  to psram
- mem_write_ack  in  1  from psram
- mem_read_ack  in  1  from psram
- mem_read_avail  in  1  from psram
- mem_data_out  in  16  from psram
- mem_busy  in  1  from psram

Behaviour:
- Reset (async assert, sync release): every output = 0, state = IDLE, last-grant pointer = NUM_PORTS-1, timeout counter = 0. Reset mid-transaction abandons it with no done pulse; the PSRAM enables drop immediately.
- Edge detection: prev_* registers on mem_write_ack, mem_read_ack, mem_read_avail and mem_busy; only rising edges (falling for busy) are qualified.
- IDLE:
  - If any req bit is set, select a winner: lowest index when fixed priority; first set bit at or after last+1 (modulo NUM_PORTS) when round-robin.
  - Latch that port's we/addr/wdata/be into registers; mem_* outputs are driven only from these registers.
  - Set grant, update last, go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE: assert mem_write_en or mem_read_en for exactly one cycle; go to WAIT_ACK.
- WAIT_ACK: hold on rising edge of mem_write_ack (write) or mem_read_ack (read); exit to WAIT_DONE.
- WAIT_DONE: hold on falling edge of mem_busy (write) or rising edge of mem_read_avail (read); on read, capture mem_data_out into rdata; exit to DONE.
- DONE: done[granted] = 1 for one cycle, err = 0; grant clears on exit; return to IDLE.
- Timeout:
  - The counter resets on entry to ISSUE and increments in WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err = 1 and rdata = 0.
- Requester contract: a registered requester sees done, then drops req (or presents a new request) on the same edge. IDLE samples the following cycle, so back-to-back requests from one port are legal. With ROUND_ROBIN, a port with req still high is not re-granted ahead of other pending ports.
- req changes while granted are ignored, because the request fields are latched.
- Simultaneous requests in IDLE: exactly one grant, per the arbitration mode.
- Minimum transaction: 4 cycles plus PSRAM latency. Throughput is one transaction at a time.

Decomposition:
- Package psram_arbiter_pkg:
  - state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE)
  - PSRAM_ADDR_W = 22, PSRAM_DATA_W = 16
  - function rr_pick(req, last) returning a one-hot vector
- One natural sub-module: arb_picker (combinational fixed/round-robin selector, parameterised on NUM_PORTS and ROUND_ROBIN), reusable elsewhere.

Test Plan:
- Single write, port 2: addr 0x00123, wdata 0xBEEF, be 2'b11; model write_ack 3 cycles after write_en, busy falls 5 cycles later -> exactly one write_en pulse with mem_addr 0x00123 and mem_data_in 0xBEEF; done[2] once, err = 0.
- Single read, port 1, addr 0x3FFFFF; model returns 0x1234 on avail -> done[1] with rdata 0x1234, read_en pulsed once.
- All three ports request continuously, ROUND_ROBIN = 1 -> grant order 0, 1, 2, 0, 1, 2; with ROUND_ROBIN = 0 -> port 0 always wins while its req is held.
- Timeout: model never raises read_ack, TIMEOUT_CYCLES = 15 -> done with err = 1, rdata = 0, 17 cycles after ISSUE; the next request is still served normally.
- reset_n asserted during WAIT_DONE -> all outputs 0 asynchronously, no done pulse; after release, a pending request is re-granted from IDLE.
- Back-to-back writes on port 0 with req held through done, then a new addr -> second ISSUE two cycles after the first done, with the new latched address.
